// File: rtl/traffic_sched.sv
// Per-lane traffic tick scheduler with difficulty levels, game pause and respawn freeze.
// Build option: define TRAFFIC_ALT_DIR_EN to make odd lanes move right (alternating traffic).
module traffic_sched #(
    parameter int NUM_LANES     = 4,
    parameter int BASE_DIV      = 3000000,
    parameter int LANE_SKEW     = 250000,
    parameter int FREEZE_CYCLES = 1000000
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 level_up,
    input  logic                 pause,
    input  logic                 frog_dead,
    output logic [NUM_LANES-1:0] lane_tick,
    output logic [1:0]           level,
    output logic [1:0]           state,
    output logic [NUM_LANES-1:0] lane_dir
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam int              FZ_W    = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
    localparam logic [FZ_W-1:0] FZ_LOAD = FZ_W'(FREEZE_CYCLES - 1);

    // Counter reload value P(i)-1 for a given difficulty level.
    function automatic logic [21:0] reload_val(input logic [1:0] lvl, input int lane);
        int p;
        p = (BASE_DIV >> lvl) + lane * LANE_SKEW;
        return 22'(p - 1);
    endfunction

    logic [1:0]           state_q, state_d;
    logic [1:0]           level_q, level_d;
    logic [FZ_W-1:0]      fz_q, fz_d;
    logic [21:0]          cnt_q [NUM_LANES];
    logic [21:0]          cnt_d [NUM_LANES];
    logic [NUM_LANES-1:0] tick_q, tick_d;
    logic                 reload;
    logic                 count;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        fz_d    = fz_q;
        cnt_d   = cnt_q;
        tick_d  = '0;
        reload  = 1'b0;
        count   = 1'b0;

        if (level_up && level_q != 2'd3) begin
            level_d = level_q + 2'd1;
        end

        if (state_q == ST_FROZEN) begin
            // frog_dead is ignored here; a level change is latched into the held counters.
            reload = level_up;
            if (fz_q == '0) begin
                state_d = pause ? ST_PAUSED : ST_RUN;
            end else begin
                fz_d = fz_q - 1'b1;
            end
        end else if (frog_dead) begin
            state_d = ST_FROZEN;
            fz_d    = FZ_LOAD;
            reload  = 1'b1;
        end else begin
            state_d = pause ? ST_PAUSED : ST_RUN;
            reload  = level_up;
            count   = !level_up && !pause;
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            if (reload) begin
                cnt_d[i] = reload_val(level_d, i);
            end else if (count) begin
                if (cnt_q[i] == 22'd0) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = reload_val(level_q, i);
                end else begin
                    cnt_d[i] = cnt_q[i] - 22'd1;
                end
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            level_q <= 2'd0;
            fz_q    <= '0;
            tick_q  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= reload_val(2'd0, i);
            end
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            fz_q    <= fz_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lane_tick = tick_q;
    assign level     = level_q;
    assign state     = state_q;

`ifdef TRAFFIC_ALT_DIR_EN
    always_comb begin
        lane_dir = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_dir[i] = ((i % 2) == 1);
        end
    end
`else
    assign lane_dir = '0;
`endif

endmodule

// File: tb/tb_traffic_sched.sv
// Self-checking bench for traffic_sched: elapsed-time lane model compared every cycle,
// plus directed scenarios with hand-computed tick positions.
module tb_traffic_sched;

    localparam int NL   = 4;
    localparam int BASE = 8;
    localparam int SKEW = 2;
    localparam int FRZ  = 5;

`ifdef TRAFFIC_ALT_DIR_EN
    localparam logic [NL-1:0] EXP_DIR = 4'b1010;
`else
    localparam logic [NL-1:0] EXP_DIR = 4'b0000;
`endif

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b1;
    logic          level_up  = 1'b0;
    logic          pause     = 1'b0;
    logic          frog_dead = 1'b0;
    logic [NL-1:0] lane_tick;
    logic [NL-1:0] lane_dir;
    logic [1:0]    level;
    logic [1:0]    state;

    traffic_sched #(
        .NUM_LANES    (NL),
        .BASE_DIV     (BASE),
        .LANE_SKEW    (SKEW),
        .FREEZE_CYCLES(FRZ)
    ) dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .level_up (level_up),
        .pause    (pause),
        .frog_dead(frog_dead),
        .lane_tick(lane_tick),
        .level    (level),
        .state    (state),
        .lane_dir (lane_dir)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int            m_state = 0;
    int            m_level = 0;
    int            m_fz    = 0;
    int            m_el [NL] = '{default: 0};
    logic [NL-1:0] m_tick  = '0;
    int            m_new_lvl;
    bit            m_reload;
    bit            m_count;

    function automatic int period(input int l, input int i);
        return (BASE >> l) + i * SKEW;
    endfunction

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            m_state = 0;
            m_level = 0;
            m_fz    = 0;
            m_tick  = '0;
            for (int i = 0; i < NL; i++) m_el[i] = 0;
        end else begin
            m_tick    = '0;
            m_reload  = 1'b0;
            m_count   = 1'b0;
            m_new_lvl = (level_up && m_level < 3) ? m_level + 1 : m_level;
            if (m_state == 2) begin
                m_reload = level_up;
                if (m_fz == 1) m_state = pause ? 1 : 0;
                else           m_fz    = m_fz - 1;
            end else if (frog_dead) begin
                m_state  = 2;
                m_fz     = FRZ;
                m_reload = 1'b1;
            end else begin
                m_state  = pause ? 1 : 0;
                m_reload = level_up;
                m_count  = !level_up && !pause;
            end
            m_level = m_new_lvl;
            for (int i = 0; i < NL; i++) begin
                if (m_reload) begin
                    m_el[i] = 0;
                end else if (m_count) begin
                    m_el[i] = m_el[i] + 1;
                    if (m_el[i] == period(m_level, i)) begin
                        m_el[i]   = 0;
                        m_tick[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- literal expectations queued for the checker ----------------
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    lit_t lit_q [$];
    int   lit_rd = 0;

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_t t;
        t.name = n;
        t.act  = a;
        t.exp  = e;
        lit_q.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge frame_clk) begin
        chk("lane_tick", 32'(lane_tick), 32'(m_tick));
        chk("level",     32'(level),     m_level);
        chk("state",     32'(state),     m_state);
        chk("lane_dir",  32'(lane_dir),  32'(EXP_DIR));
        while (lit_rd < lit_q.size()) begin
            chk(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    int first_t [NL];
    int sec_t   [NL];
    int n_t     [NL];
    int n_frz;

    task automatic step();
        @(posedge frame_clk);
        #2;
    endtask

    task automatic watch(input int n, input int frog_k);
        for (int i = 0; i < NL; i++) begin
            first_t[i] = 0;
            sec_t[i]   = 0;
            n_t[i]     = 0;
        end
        n_frz = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            for (int i = 0; i < NL; i++) begin
                if (lane_tick[i]) begin
                    n_t[i]++;
                    if (first_t[i] == 0)    first_t[i] = k;
                    else if (sec_t[i] == 0) sec_t[i]   = k;
                end
            end
            if (state == 2'd2) n_frz++;
            frog_dead = (k == frog_k);
        end
        frog_dead = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        lit("rst_state", 32'(state), 0);
        lit("rst_level", 32'(level), 0);
        lit("rst_tick",  32'(lane_tick), 0);
        lit("dir",       32'(lane_dir), 32'(EXP_DIR));

        // Free running at level 0 after release.
        Reset = 1'b0;
        watch(40, 0);
        lit("l0_first0", first_t[0], 8);  lit("l0_sec0", sec_t[0], 16);
        lit("l0_first1", first_t[1], 10); lit("l0_sec1", sec_t[1], 20);
        lit("l0_first2", first_t[2], 12); lit("l0_sec2", sec_t[2], 24);
        lit("l0_first3", first_t[3], 14); lit("l0_sec3", sec_t[3], 28);
        lit("l0_count0", n_t[0], 5);

        // Four level_up pulses, saturating at 3.
        for (int p = 1; p <= 4; p++) begin
            level_up = 1'b1;
            step();
            level_up = 1'b0;
            lit("lvl_after_pulse", 32'(level), (p < 3) ? p : 3);
            if (p < 4) step();
        end
        lit("lvl_reload_notick", 32'(lane_tick), 0);
        watch(14, 0);
        lit("l3_count0", n_t[0], 14);
        lit("l3_first0", first_t[0], 1);
        lit("l3_first1", first_t[1], 3);
        lit("l3_first3", first_t[3], 7);
        lit("l3_sec3",   sec_t[3], 14);

        // Pause for 20 cycles mid-period.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        watch(3, 0);
        pause = 1'b1;
        watch(20, 0);
        lit("pause_state",  32'(state), 1);
        lit("pause_notick", n_t[0] + n_t[1] + n_t[2] + n_t[3], 0);
        pause = 1'b0;
        watch(10, 0);
        lit("resume_first0", first_t[0], 5);
        lit("resume_first1", first_t[1], 7);

        // Freeze with a second frog_dead that must be ignored.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        watch(3, 0);
        frog_dead = 1'b1;
        step();
        frog_dead = 1'b0;
        lit("frz_state", 32'(state), 2);
        watch(20, 1);
        lit("frz_rest_len", n_frz, 4);
        lit("frz_first0",   first_t[0], 13);
        lit("frz_first3",   first_t[3], 19);

        // level_up during freeze, exit into PAUSED, resume at level 1 periods.
        frog_dead = 1'b1;
        step();
        frog_dead = 1'b0;
        level_up  = 1'b1;
        step();
        level_up  = 1'b0;
        lit("frzlvl_level", 32'(level), 1);
        lit("frzlvl_state", 32'(state), 2);
        pause = 1'b1;
        watch(6, 0);
        lit("frz_exit_paused", 32'(state), 1);
        lit("frz_exit_notick", n_t[0], 0);
        pause = 1'b0;
        watch(12, 0);
        lit("lvl1_first0", first_t[0], 4);
        lit("lvl1_sec0",   sec_t[0], 8);
        lit("lvl1_first3", first_t[3], 10);

        // Coincident frog_dead + level_up, then Reset during the freeze.
        frog_dead = 1'b1;
        level_up  = 1'b1;
        step();
        frog_dead = 1'b0;
        level_up  = 1'b0;
        lit("coinc_state", 32'(state), 2);
        lit("coinc_level", 32'(level), 2);
        step();
        step();
        Reset = 1'b1;
        #1;
        lit("rstfrz_state", 32'(state), 0);
        lit("rstfrz_level", 32'(level), 0);
        lit("rstfrz_tick",  32'(lane_tick), 0);
        step();
        Reset = 1'b0;
        watch(20, 0);
        lit("post_rst_first0", first_t[0], 8);
        lit("post_rst_count0", n_t[0], 2);
        lit("post_rst_first3", first_t[3], 14);

        // Reset while paused.
        pause = 1'b1;
        watch(5, 0);
        Reset = 1'b1;
        #1;
        lit("rstpause_state", 32'(state), 0);
        pause = 1'b0;
        step();
        Reset = 1'b0;
        watch(10, 0);
        lit("rstpause_first0", first_t[0], 8);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_sched.md
TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of car lanes sequenced.
REQ-002 SHALL have parameter BASE_DIV, default 3000000, level-0 tick period in frame_clk cycles.
REQ-003 SHALL have parameter LANE_SKEW, default 250000, extra period per lane index.
REQ-004 SHALL have parameter FREEZE_CYCLES, default 1000000, respawn freeze length.
REQ-005 SHALL have port frame_clk, input, 1, clock.
REQ-006 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port level_up, input, 1, one-cycle pulse requesting the next difficulty level.
REQ-008 SHALL have port pause, input, 1, level-sensitive game pause.
REQ-009 SHALL have port frog_dead, input, 1, one-cycle pulse on collision.
REQ-010 SHALL have port lane_tick, output, NUM_LANES, one-cycle move enable per lane.
REQ-011 SHALL have port level, output, 2, current difficulty level 0..3.
REQ-012 SHALL have port state, output, 2, FSM state code: RUN=0, PAUSED=1, FROZEN=2.
REQ-013 SHALL have port lane_dir, output, NUM_LANES, 1 = lane moves right, 0 = left.

Function
REQ-014 SHALL keep one 22-bit down-counter per lane; lane i period P(i) = (BASE_DIV >> level) + i*LANE_SKEW.
REQ-015 SHALL, in RUN, assert lane_tick[i] for exactly one cycle when counter i equals 0, and reload counter i with P(i)-1 in that same cycle; otherwise decrement.
REQ-016 SHALL, in RUN, give tick spacing of exactly P(i) cycles per lane; first tick after entering RUN occurs P(i) cycles after entry.
REQ-017 SHALL, on level_up, saturate level at 3 (increment only if level<3) and reload all counters with the new P(i)-1 on the next cycle; no tick in that cycle.
REQ-018 SHALL transition RUN->PAUSED while pause=1; counters hold, lane_tick=0; PAUSED->RUN when pause=0, counters resume from held values.
REQ-019 SHALL transition RUN or PAUSED->FROZEN on frog_dead; load freeze counter with FREEZE_CYCLES-1, lane_tick=0, lane counters reload to P(i)-1.
REQ-020 SHALL leave FROZEN after FREEZE_CYCLES cycles, to PAUSED if pause=1 else RUN; pause does not shorten or extend FROZEN.
REQ-021 SHALL, on simultaneous events, use priority frog_dead > level_up > pause; level_up coincident with frog_dead still increments level.
REQ-022 SHALL accept level_up in any state; a level_up received during FROZEN updates level and takes effect on exit.
REQ-023 SHALL ignore frog_dead while FROZEN (freeze counter not restarted).

Reset
REQ-024 SHALL, on Reset, immediately set state=RUN, level=0, lane_tick=0, all lane counters to P(i)-1 at level 0, freeze counter to 0.
REQ-025 SHALL abort any in-progress freeze or pause on Reset, mid-operation, with no residual tick after release.

Configuration
REQ-026 SHALL, with macro TRAFFIC_ALT_DIR_EN defined, drive lane_dir[i]=1 for odd i and 0 for even i (alternating traffic).
REQ-027 SHALL, without TRAFFIC_ALT_DIR_EN, drive lane_dir to all zeros (all lanes move left); tick timing identical in both builds.

Verification (BASE_DIV=8, LANE_SKEW=2, FREEZE_CYCLES=5, NUM_LANES=4)
REQ-028 SHALL cover: release Reset, run 40 cycles -> lane0 ticks every 8, lane1 every 10, lane2 every 12, lane3 every 14, each one cycle wide.
REQ-029 SHALL cover: level_up pulse x4 -> level 1,2,3,3; at level 3 lane0 period 1, lane3 period 7.
REQ-030 SHALL cover: pause high 20 cycles mid-period -> state=1, no ticks, next tick after release at remaining count.
REQ-031 SHALL cover: frog_dead -> state=2 for exactly 5 cycles, no ticks, then RUN with lane0 tick 8 cycles later; second frog_dead during freeze ignored.
REQ-032 SHALL cover: frog_dead and level_up same cycle -> FROZEN and level incremented; Reset asserted during FROZEN -> state=0, level=0, lane_tick=0.
REQ-033 SHALL cover: both builds -> lane_dir = 4'b1010 with TRAFFIC_ALT_DIR_EN, 4'b0000 without.
